// File: rtl/ysyx_23060124_ifu_axi.sv
// Multi-cycle instruction fetch: one AXI4-Lite read per instruction, result handed to the IDU
// via valid/ready, then held until the PCU retires it with the next PC.
module ysyx_23060124_ifu_axi #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_pc_update,
  input  logic [ADDR_W-1:0] i_pc_next,
  output logic [ADDR_W-1:0] o_pc,
  output logic [DATA_W-1:0] o_ins,
  output logic              o_ins_valid,
  input  logic              i_ins_ready,
  output logic              o_ins_err,
  output logic [ADDR_W-1:0] o_araddr,
  output logic              o_arvalid,
  input  logic              i_arready,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [1:0]        i_rresp,
  input  logic              i_rvalid,
  output logic              o_rready,
  output logic [31:0]       o_fetch_cnt
);

  typedef enum logic [1:0] {
    S_AR   = 2'd0,
    S_R    = 2'd1,
    S_OUT  = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   ins_q, ins_d;
  logic                err_q, err_d;
  logic [31:0]         cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state_q <= S_AR;
      pc_q    <= RESET_PC;
      ins_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ins_q   <= ins_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // A retirement pulse outside S_OUT+ready or S_WAIT is dropped on purpose.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ins_d   = ins_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_AR: begin
        if (i_arready) state_d = S_R;
      end
      S_R: begin
        if (i_rvalid) begin
          ins_d   = i_rdata;
          err_d   = (i_rresp != 2'b00);
          cnt_d   = cnt_q + 32'd1;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (i_ins_ready) begin
          if (i_pc_update) begin
            pc_d    = i_pc_next;
            state_d = S_AR;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (i_pc_update) begin
          pc_d    = i_pc_next;
          state_d = S_AR;
        end
      end
      default: state_d = S_AR;
    endcase
  end

  // Handshake outputs are state decodes, only qualified by reset so nothing is offered while held.
  assign o_arvalid   = i_rst_n && (state_q == S_AR);
  assign o_rready    = i_rst_n && (state_q == S_R);
  assign o_ins_valid = i_rst_n && (state_q == S_OUT);
  assign o_araddr    = pc_q;
  assign o_pc        = pc_q;
  assign o_ins       = ins_q;
  assign o_ins_err   = err_q;
  assign o_fetch_cnt = cnt_q;

endmodule
